// File: rtl/int_arbiter_pkg.sv
// Shared constants, types and helpers for the interrupt arbiter.
package int_arbiter_pkg;

  localparam int NUM_IRQ = 4;
  localparam int ID_W    = 2;

  // Arbiter FSM encodings; the unused code 2'd3 behaves as IDLE.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SERV = 2'd2;

  typedef logic [ID_W-1:0]    irq_id_t;
  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  // One-hot select of a single interrupt line.
  function automatic irq_vec_t id_onehot(input irq_id_t id);
    id_onehot     = '0;
    id_onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/int_arbiter_prio_enc4.sv
// Four-input rotating priority encoder: the first set request at or after
// 'start' (wrapping 3->0) wins. start=0 gives plain fixed priority.
module prio_enc4
  import int_arbiter_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  logic [NUM_IRQ-1:0] rot;
  logic [ID_W-1:0]    off;

  // Rotate so that bit 0 corresponds to the search start position.
  assign rot = NUM_IRQ'({req, req} >> start);

  // Lowest set bit of the rotated vector is the winner's offset from start.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    off = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = ID_W'(k);
      end
    end
  end

  assign valid = |req;
  assign idx   = start + off;

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter between four external request lines and the CPU control
// unit. Rising edges are latched as pending, a writable mask gates them, one
// winner is committed and presented as a handler vector. The in-service state
// lasts until return-from-interrupt, so handlers never nest.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int                 AW         = 10,
  parameter logic [AW-1:0]      VEC_BASE   = 10'h3F0,
  parameter int                 VEC_STRIDE = 4,
  parameter bit                 RR         = 1'b0,
  parameter logic [NUM_IRQ-1:0] MASK_RST   = 4'b0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_d,
  input  logic               int_ack,
  input  logic               fin_int,
  output logic               int_req,
  output logic [AW-1:0]      int_vec,
  output logic [ID_W-1:0]    int_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  logic [1:0]    state_q,    state_d;
  irq_vec_t      irq_q,      irq_d;
  irq_vec_t      pending_q,  pending_d;
  irq_vec_t      mask_reg_q, mask_reg_d;
  irq_id_t       int_id_q,   int_id_d;
  logic [AW-1:0] int_vec_q,  int_vec_d;
  irq_id_t       rr_ptr_q,   rr_ptr_d;

  irq_vec_t      rise;
  irq_vec_t      eligible;
  irq_vec_t      clr;
  irq_id_t       search_start;
  logic          win_valid;
  irq_id_t       win_idx;
  logic [AW-1:0] vec_calc;

  // Edge detection and the arbitration candidates.
  assign rise         = irq & ~irq_q;
  assign eligible     = pending_q & ~mask_reg_q;
  assign search_start = RR ? rr_ptr_q : '0;

  prio_enc4 u_prio_enc (
    .req   (eligible),
    .start (search_start),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Handler address wraps modulo 2^AW.
  assign vec_calc = VEC_BASE + (AW'(win_idx) * AW'(VEC_STRIDE));

  // FSM: commit a winner in IDLE, wait for ack in REQ, wait for return in SERV.
  always_comb begin
    state_d   = state_q;
    int_id_d  = int_id_q;
    int_vec_d = int_vec_q;
    rr_ptr_d  = rr_ptr_q;
    clr       = '0;
    case (state_q)
      S_REQ: begin
        if (int_ack) begin
          clr     = id_onehot(int_id_q);
          state_d = S_SERV;
        end
      end
      S_SERV: begin
        if (fin_int) begin
          rr_ptr_d = int_id_q + ID_W'(1);
          state_d  = S_IDLE;
        end
      end
      default: begin
        // S_IDLE and the unused encoding both arbitrate.
        if (win_valid) begin
          int_id_d  = win_idx;
          int_vec_d = vec_calc;
          state_d   = S_REQ;
        end
      end
    endcase
  end

  // Pending latch (a new rise beats a same-cycle clear), edge history and mask.
  always_comb begin
    irq_d      = irq;
    pending_d  = (pending_q & ~clr) | rise;
    mask_reg_d = mask_we ? mask_d : mask_reg_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: flops are written with <= so every register samples the pre-edge values, independent of block order.
      state_q    <= S_IDLE;
      irq_q      <= '0;
      pending_q  <= '0;
      mask_reg_q <= MASK_RST;
      int_id_q   <= '0;
      int_vec_q  <= VEC_BASE;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      pending_q  <= pending_d;
      mask_reg_q <= mask_reg_d;
      int_id_q   <= int_id_d;
      int_vec_q  <= int_vec_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Outputs decode straight from registers, so they cannot glitch.
  assign int_req    = (state_q == S_REQ);
  assign in_service = (state_q == S_SERV);
  assign int_vec    = int_vec_q;
  assign int_id     = int_id_q;
  assign pending    = pending_q;
  assign mask       = mask_reg_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter. Three instances share the stimulus:
// u0 fixed priority, u1 round-robin, u2 fixed priority with a vector base that
// wraps and a non-zero reset mask. A behavioural model tracks each instance
// and a compare process checks all outputs every cycle; directed literal
// checks pin the model to hand-computed values.
module tb_int_arbiter;

  localparam int NI = 3;

  typedef enum int {P_IDLE, P_WAIT_ACK, P_HANDLER} phase_t;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_d;
  logic       int_ack;
  logic       fin_int;

  logic       int_req_o    [NI];
  logic [9:0] int_vec_o    [NI];
  logic [1:0] int_id_o     [NI];
  logic       in_service_o [NI];
  logic [3:0] pending_o    [NI];
  logic [3:0] mask_o       [NI];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Instance configuration, shared by the DUT parameters and the model.
  function automatic logic [9:0] base_of(input int k);
    return (k == 2) ? 10'h3FC : 10'h3F0;
  endfunction
  function automatic bit rr_of(input int k);
    return (k == 1);
  endfunction
  function automatic logic [3:0] mrst_of(input int k);
    return (k == 2) ? 4'b1000 : 4'b0000;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    int_arbiter #(
      .AW         (10),
      .VEC_BASE   (base_of(g)),
      .VEC_STRIDE (4),
      .RR         (rr_of(g)),
      .MASK_RST   (mrst_of(g))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .mask_we    (mask_we),
      .mask_d     (mask_d),
      .int_ack    (int_ack),
      .fin_int    (fin_int),
      .int_req    (int_req_o[g]),
      .int_vec    (int_vec_o[g]),
      .int_id     (int_id_o[g]),
      .in_service (in_service_o[g]),
      .pending    (pending_o[g]),
      .mask       (mask_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_pend [NI];
  logic [3:0] m_mask [NI];
  logic [3:0] m_prev [NI];
  phase_t     m_ph   [NI];
  int         m_id   [NI];
  int         m_ptr  [NI];

  // First eligible line found scanning upward from 'start', wrapping.
  function automatic int pick(input logic [3:0] e, input int start);
    for (int j = 0; j < 4; j++) begin
      if (e[(start + j) % 4]) return (start + j) % 4;
    end
    return 0;
  endfunction

  function automatic logic [9:0] exp_vec(input int k, input int id);
    return 10'(int'(base_of(k)) + id * 4);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      for (int k = 0; k < NI; k++) begin
        if (!reset) begin
          m_pend[k] = '0;
          m_mask[k] = mrst_of(k);
          m_prev[k] = '0;
          m_ph[k]   = P_IDLE;
          m_id[k]   = 0;
          m_ptr[k]  = 0;
        end else begin
          logic [3:0] elig;
          logic [3:0] rise;
          logic [3:0] clear;
          elig  = m_pend[k] & ~m_mask[k];
          rise  = irq & ~m_prev[k];
          clear = '0;
          case (m_ph[k])
            P_IDLE: if (elig != 0) begin
              m_id[k] = pick(elig, rr_of(k) ? m_ptr[k] : 0);
              m_ph[k] = P_WAIT_ACK;
            end
            P_WAIT_ACK: if (int_ack) begin
              clear[m_id[k]] = 1'b1;
              m_ph[k] = P_HANDLER;
            end
            default: if (fin_int) begin
              m_ptr[k] = (m_id[k] + 1) % 4;
              m_ph[k]  = P_IDLE;
            end
          endcase
          m_pend[k] = (m_pend[k] & ~clear) | rise;
          if (mask_we) m_mask[k] = mask_d;
          m_prev[k] = irq;
        end
      end
    end
  end

  // Compare every instance against the model once per cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < NI; k++) begin
          check($sformatf("u%0d.int_req", k),    32'(int_req_o[k]),    32'(m_ph[k] == P_WAIT_ACK));
          check($sformatf("u%0d.in_service", k), 32'(in_service_o[k]), 32'(m_ph[k] == P_HANDLER));
          check($sformatf("u%0d.int_id", k),     32'(int_id_o[k]),     32'(m_id[k]));
          check($sformatf("u%0d.int_vec", k),    32'(int_vec_o[k]),    32'(exp_vec(k, m_id[k])));
          check($sformatf("u%0d.pending", k),    32'(pending_o[k]),    32'(m_pend[k]));
          check($sformatf("u%0d.mask", k),       32'(mask_o[k]),       32'(m_mask[k]));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    fin_int = 1'b1;
    tick();
    fin_int = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    irq     = 4'hF;
    mask_we = 1'b0;
    mask_d  = 4'h0;
    int_ack = 1'b0;
    fin_int = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;

    // Reset with all lines high
    check("rst pending",  32'(pending_o[0]), 32'h0);
    check("rst int_req",  32'(int_req_o[0]), 32'h0);
    check("rst mask",     32'(mask_o[0]),    32'h0);
    check("rst int_vec",  32'(int_vec_o[0]), 32'h3F0);
    check("rst int_id",   32'(int_id_o[0]),  32'h0);
    check("rst u2 mask",  32'(mask_o[2]),    32'h8);
    check("rst u2 vec",   32'(int_vec_o[2]), 32'h3FC);
    irq = 4'h0;
    tick();
    reset = 1'b1;
    tick();

    // Single request on line 2
    irq = 4'b0100;
    tick();
    check("single pending", 32'(pending_o[0]), 32'h4);
    check("single no req yet", 32'(int_req_o[0]), 32'h0);
    tick();
    check("single int_req", 32'(int_req_o[0]), 32'h1);
    check("single int_id",  32'(int_id_o[0]),  32'h2);
    check("single int_vec", 32'(int_vec_o[0]), 32'h3F8);
    check("u2 vec wrap 404", 32'(int_vec_o[2]), 32'h004);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("ack pending clr", 32'(pending_o[0]),    32'h0);
    check("ack in_service",  32'(in_service_o[0]), 32'h1);
    check("ack int_req low", 32'(int_req_o[0]),    32'h0);
    tick();
    check("level held once", 32'(pending_o[0]), 32'h0);
    fin_int = 1'b1;
    tick();
    fin_int = 1'b0;
    check("fin in_service", 32'(in_service_o[0]), 32'h0);
    check("fin int_req",    32'(int_req_o[0]),    32'h0);

    // Service line 1 once so the round-robin pointer of u1 lands on 2
    irq = 4'h0;
    tick();
    irq = 4'b0010;
    tick();
    tick();
    serve();
    irq = 4'h0;
    tick();

    // Simultaneous requests on lines 1 and 3
    irq = 4'b1010;
    tick();
    tick();
    check("sim u0 int_id",  32'(int_id_o[0]),  32'h1);
    check("sim u0 int_vec", 32'(int_vec_o[0]), 32'h3F4);
    check("sim u1 rr id",   32'(int_id_o[1]),  32'h3);
    check("sim u1 rr vec",  32'(int_vec_o[1]), 32'h3FC);
    check("u2 vec wrap 000", 32'(int_vec_o[2]), 32'h000);
    serve();
    tick();
    check("sim2 u0 int_req", 32'(int_req_o[0]), 32'h1);
    check("sim2 u0 int_id",  32'(int_id_o[0]),  32'h3);
    check("sim2 u0 int_vec", 32'(int_vec_o[0]), 32'h3FC);
    check("sim2 u1 int_id",  32'(int_id_o[1]),  32'h1);
    check("u2 masked idle",  32'(int_req_o[2]), 32'h0);
    serve();

    // Masking line 0
    irq     = 4'h0;
    mask_we = 1'b1;
    mask_d  = 4'b0001;
    tick();
    mask_we = 1'b0;
    irq     = 4'b0001;
    tick();
    check("mask pending",  32'(pending_o[0]), 32'h1);
    check("mask no req",   32'(int_req_o[0]), 32'h0);
    tick();
    check("mask still no req", 32'(int_req_o[0]), 32'h0);
    check("mask value",    32'(mask_o[0]),    32'h1);
    mask_we = 1'b1;
    mask_d  = 4'b0000;
    tick();
    mask_we = 1'b0;
    check("unmask +1 no req", 32'(int_req_o[0]), 32'h0);
    tick();
    check("unmask +2 int_req", 32'(int_req_o[0]), 32'h1);
    check("unmask int_id",     32'(int_id_o[0]),  32'h0);
    serve();

    // Set/clear collision on line 1
    irq = 4'h0;
    tick();
    irq = 4'b0010;
    tick();
    tick();
    check("coll req",    32'(int_req_o[0]), 32'h1);
    check("coll int_id", 32'(int_id_o[0]),  32'h1);
    irq = 4'h0;
    tick();
    irq     = 4'b0010;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("coll set wins", 32'(pending_o[0][1]), 32'h1);
    check("coll in_service", 32'(in_service_o[0]), 32'h1);
    fin_int = 1'b1;
    tick();
    fin_int = 1'b0;
    check("coll idle", 32'(int_req_o[0]), 32'h0);
    tick();
    check("coll re-req",    32'(int_req_o[0]), 32'h1);
    check("coll re-req id", 32'(int_id_o[0]),  32'h1);
    serve();

    // Reset while in service
    irq = 4'h0;
    tick();
    irq = 4'b0100;
    tick();
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    mask_we = 1'b1;
    mask_d  = 4'b1111;
    tick();
    mask_we = 1'b0;
    check("pre-rst in_service", 32'(in_service_o[0]), 32'h1);
    check("pre-rst mask",       32'(mask_o[0]),       32'hF);
    #2;
    reset = 1'b0;
    #1;
    check("mid-rst in_service", 32'(in_service_o[0]), 32'h0);
    check("mid-rst int_req",    32'(int_req_o[0]),    32'h0);
    check("mid-rst pending",    32'(pending_o[0]),    32'h0);
    check("mid-rst mask",       32'(mask_o[0]),       32'h0);
    check("mid-rst u2 mask",    32'(mask_o[2]),       32'h8);
    irq = 4'h0;
    tick();
    reset   = 1'b1;
    fin_int = 1'b1;
    tick();
    fin_int = 1'b0;
    check("stray fin in_service", 32'(in_service_o[0]), 32'h0);
    check("stray fin int_req",    32'(int_req_o[0]),    32'h0);
    check("stray fin pending",    32'(pending_o[0]),    32'h0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
